// File: rtl/event_scheduler.sv
// -----------------------------------------------------------------------------
// event_scheduler
//
// Collects input-stream updates and periodic deadlines into timestamped events,
// buffers them in a small FIFO and hands them one at a time to an evaluation
// datapath through a valid/ready handshake. After each accepted event the
// datapath is given EVAL_CYCLES cycles before the next event is offered.
//
// Parameters
//   DATA_W       input/output value width
//   TS_W         timestamp width (wraps modulo 2^TS_W)
//   PERIOD       periodic-stream period in enabled cycles (>= 2)
//   QDEPTH       event queue depth (power of 2, >= 2)
//   EVAL_CYCLES  evaluation cycles per event (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   en           global enable; low freezes every counter, the FSM and the queue
//   input_0      input stream value, qualified by new_input_0
//   new_input_0  input_0 carries a new value this cycle
//   ev_data      value of the event being offered
//   ev_ts        timestamp of the event being offered
//   ev_valid     event offered to the datapath
//   ev_ready     datapath accepts the offered event
//   enable_in0   input stream 0 update strobe (handshake cycle only)
//   enable_out0  event-based output 0 strobe (handshake cycle only)
//   enable_out1  periodic output 1 strobe (handshake cycle only)
//   q_push       an entry was formed this cycle
//   q_push_valid the formed entry was written into the queue
//   q_pop        the queue head was removed this cycle
//   q_pop_valid  the removed entry was valid (always equals q_pop)
//   overflow     sticky: at least one entry was dropped since reset
// -----------------------------------------------------------------------------
module event_scheduler #(
   parameter int DATA_W      = 64,
   parameter int TS_W        = 32,
   parameter int PERIOD      = 500,
   parameter int QDEPTH      = 4,
   parameter int EVAL_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] input_0,
   input  logic                     new_input_0,
   output logic signed [DATA_W-1:0] ev_data,
   output logic        [TS_W-1:0]   ev_ts,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic                     enable_in0,
   output logic                     enable_out0,
   output logic                     enable_out1,
   output logic                     q_push,
   output logic                     q_push_valid,
   output logic                     q_pop,
   output logic                     q_pop_valid,
   output logic                     overflow
);

   localparam int PER_W = $clog2(PERIOD);
   localparam int EC_W  = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
   localparam int QA_W  = $clog2(QDEPTH);
   localparam int CNT_W = QA_W + 1;

   localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(PERIOD - 1);
   localparam logic [EC_W-1:0]  EVAL_LOAD  = EC_W'(EVAL_CYCLES - 1);
   localparam logic [CNT_W-1:0] Q_FULL     = CNT_W'(QDEPTH);

   typedef struct packed {
      logic                     in_bit;
      logic                     dl_bit;
      logic signed [DATA_W-1:0] data;
      logic        [TS_W-1:0]   ts;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_EVAL  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Timestamp and period counters
   // ---------------------------------------------------------------------------
   logic [TS_W-1:0]  ts_q;
   logic [PER_W-1:0] per_q;
   logic             deadline;

   assign deadline = en && (per_q == '0);

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q  <= '0;
         per_q <= PER_RELOAD;
      end else if (en) begin
         ts_q  <= ts_q + TS_W'(1);
         per_q <= (per_q == '0) ? PER_RELOAD : per_q - PER_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Entry formation and queue control
   // ---------------------------------------------------------------------------
   state_t            state_q;
   logic [EC_W-1:0]   eval_cnt_q;
   logic              ev_valid_q;
   entry_t            cur_q;

   entry_t            mem_q [QDEPTH];
   logic [QA_W-1:0]   wr_ptr_q;
   logic [QA_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              overflow_q;

   entry_t            entry_d;
   logic              form;
   logic              q_full;
   logic              pop_ok;
   logic              push_ok;

   // rst gates formation so q_push reads 0 while reset is held, even with
   // en and new_input_0 high.
   assign form    = rst && en && (new_input_0 || deadline);
   assign q_full  = (count_q == Q_FULL);
   // A pop needs a registered non-empty count, so an entry pushed this cycle
   // can never be popped in the same cycle.
   assign pop_ok  = en && (state_q == S_IDLE) && (count_q != '0);
   // The slot freed by a simultaneous pop is reused by the push.
   assign push_ok = form && (!q_full || pop_ok);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      entry_d        = '0;
      entry_d.in_bit = new_input_0;
      entry_d.dl_bit = deadline;
      entry_d.data   = new_input_0 ? input_0 : '0;
      entry_d.ts     = ts_q;

      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage array has no reset; emptiness is tracked by the reset
   // pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= entry_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + QA_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + QA_W'(1);
         end
         count_q <= count_d;
         if (form && !push_ok) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pop FSM: IDLE pops the head, ISSUE offers it, EVAL waits for the datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         eval_cnt_q <= '0;
         ev_valid_q <= 1'b0;
         cur_q      <= '0;
      end else if (en) begin
         unique case (state_q)
            S_IDLE: begin
               if (pop_ok) begin
                  cur_q      <= mem_q[rd_ptr_q];
                  ev_valid_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (ev_ready) begin
                  ev_valid_q <= 1'b0;
                  eval_cnt_q <= EVAL_LOAD;
                  state_q    <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (eval_cnt_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  eval_cnt_q <= eval_cnt_q - EC_W'(1);
               end
            end
            default: begin
               state_q    <= S_IDLE;
               ev_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   logic fire;

   // The handshake only counts while enabled; a frozen block emits no strobe.
   assign fire = en && ev_valid_q && ev_ready;

   assign ev_valid     = ev_valid_q;
   assign ev_data      = cur_q.data;
   assign ev_ts        = cur_q.ts;
   assign enable_in0   = fire && cur_q.in_bit;
   assign enable_out0  = fire && cur_q.in_bit;
   assign enable_out1  = fire && cur_q.dl_bit;
   assign q_push       = form;
   assign q_push_valid = push_ok;
   assign q_pop        = pop_ok;
   assign q_pop_valid  = pop_ok;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_event_scheduler
//
// Directed scenarios followed by a random phase. A behavioural model tracks
// the event queue as a plain queue, the deadline as (enabled-cycle index mod
// PERIOD), and the datapath as "holding an event" plus a cool-down count;
// every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_event_scheduler;

   localparam int DATA_W      = 64;
   localparam int TS_W        = 32;
   localparam int PERIOD      = 500;
   localparam int QDEPTH      = 4;
   localparam int EVAL_CYCLES = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     en = 1'b0;
   logic signed [DATA_W-1:0] input_0 = '0;
   logic                     new_input_0 = 1'b0;
   logic                     ev_ready = 1'b0;
   logic signed [DATA_W-1:0] ev_data;
   logic        [TS_W-1:0]   ev_ts;
   logic                     ev_valid;
   logic                     enable_in0;
   logic                     enable_out0;
   logic                     enable_out1;
   logic                     q_push;
   logic                     q_push_valid;
   logic                     q_pop;
   logic                     q_pop_valid;
   logic                     overflow;

   event_scheduler #(
      .DATA_W      (DATA_W),
      .TS_W        (TS_W),
      .PERIOD      (PERIOD),
      .QDEPTH      (QDEPTH),
      .EVAL_CYCLES (EVAL_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .input_0      (input_0),
      .new_input_0  (new_input_0),
      .ev_data      (ev_data),
      .ev_ts        (ev_ts),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .enable_in0   (enable_in0),
      .enable_out0  (enable_out0),
      .enable_out1  (enable_out1),
      .q_push       (q_push),
      .q_push_valid (q_push_valid),
      .q_pop        (q_pop),
      .q_pop_valid  (q_pop_valid),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      bit                in_b;
      bit                dl_b;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } ent_t;

   ent_t              mq[$];
   bit                has_ev;
   ent_t              cur;
   int                cool;
   bit                ovf;
   longint unsigned   en_cnt;

   // Observed handshake log (DUT values captured on strobe cycles)
   logic [63:0]       obs_in_data[$];
   logic [63:0]       obs_in_ts[$];
   longint unsigned   obs_in_cyc[$];
   logic [63:0]       obs_dl_ts[$];
   int                n_all3;
   logic [63:0]       all3_data;
   logic [63:0]       all3_ts;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      obs_in_data.delete();
      obs_in_ts.delete();
      obs_in_cyc.delete();
      obs_dl_ts.delete();
      n_all3    = 0;
      all3_data = '0;
      all3_ts   = '0;
   endtask

   // One clock cycle: drive at negedge, compare 1 ns later, then advance model.
   task automatic step(input logic e, input logic ni, input logic [63:0] v, input logic rdy);
      bit   dl;
      bit   form;
      bit   pop;
      bit   fire;
      bit   push_ok;
      ent_t ne;
      @(negedge clk);
      en          = e;
      new_input_0 = ni;
      input_0     = v;
      ev_ready    = rdy;
      #1;
      dl = 1'b0; form = 1'b0; pop = 1'b0; fire = 1'b0; push_ok = 1'b0;
      if (e) begin
         dl      = (en_cnt % PERIOD) == longint'(PERIOD - 1);
         form    = ni || dl;
         pop     = !has_ev && cool == 0 && mq.size() > 0;
         fire    = has_ev && rdy;
         push_ok = form && (mq.size() < QDEPTH || pop);
      end
      check("q_push", q_push, form);
      check("q_push_valid", q_push_valid, push_ok);
      check("q_pop", q_pop, pop);
      check("q_pop_valid", q_pop_valid, pop);
      check("ev_valid", ev_valid, has_ev);
      if (has_ev) begin
         check("ev_data", ev_data, cur.data);
         check("ev_ts", ev_ts, 64'(cur.ts));
      end
      check("enable_in0", enable_in0, fire && cur.in_b);
      check("enable_out0", enable_out0, fire && cur.in_b);
      check("enable_out1", enable_out1, fire && cur.dl_b);
      check("overflow", overflow, ovf);

      if (enable_in0) begin
         obs_in_data.push_back(ev_data);
         obs_in_ts.push_back(64'(ev_ts));
         obs_in_cyc.push_back(en_cnt);
      end
      if (enable_out1) obs_dl_ts.push_back(64'(ev_ts));
      if (enable_in0 && enable_out0 && enable_out1) begin
         n_all3++;
         all3_data = ev_data;
         all3_ts   = 64'(ev_ts);
      end

      if (e) begin
         if (fire) begin
            has_ev = 1'b0;
            cool   = EVAL_CYCLES;
         end else if (cool > 0) begin
            cool--;
         end
         if (pop) begin
            cur    = mq.pop_front();
            has_ev = 1'b1;
         end
         if (push_ok) begin
            ne.in_b = ni;
            ne.dl_b = dl;
            ne.data = ni ? v : '0;
            ne.ts   = en_cnt[TS_W-1:0];
            mq.push_back(ne);
         end
         if (form && !push_ok) ovf = 1'b1;
         en_cnt++;
      end
   endtask

   // Asserts reset mid-cycle (no clock edge involved) and checks every output.
   task automatic do_reset();
      @(negedge clk);
      en          = 1'b1;
      new_input_0 = 1'b1;
      input_0     = 64'd5;
      ev_ready    = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ev_data", ev_data, 0);
      check("rst_ev_ts", 64'(ev_ts), 0);
      check("rst_enable_in0", enable_in0, 0);
      check("rst_enable_out0", enable_out0, 0);
      check("rst_enable_out1", enable_out1, 0);
      check("rst_q_push", q_push, 0);
      check("rst_q_push_valid", q_push_valid, 0);
      check("rst_q_pop", q_pop, 0);
      check("rst_q_pop_valid", q_pop_valid, 0);
      check("rst_overflow", overflow, 0);
      mq.delete();
      has_ev = 1'b0;
      cool   = 0;
      ovf    = 1'b0;
      en_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      en          = 1'b0;
      new_input_0 = 1'b0;
      rst         = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rv;

      // Reset state
      do_reset();

      // Single input at ts 10, then an input coinciding with the first deadline
      clear_logs();
      repeat (10) step(1'b1, 1'b0, 64'd0, 1'b1);
      step(1'b1, 1'b1, 64'd1, 1'b1);
      while (en_cnt < 499) step(1'b1, 1'b0, 64'd0, 1'b1);
      step(1'b1, 1'b1, 64'd3, 1'b1);
      repeat (8) step(1'b1, 1'b0, 64'd0, 1'b1);
      check("a_in_events", obs_in_data.size(), 2);
      if (obs_in_data.size() >= 2) begin
         check("a_first_data", obs_in_data[0], 64'd1);
         check("a_first_ts", obs_in_ts[0], 64'd10);
         check("a_first_latency", obs_in_cyc[0], 64'd12);
         check("a_merge_data", obs_in_data[1], 64'd3);
         check("a_merge_ts", obs_in_ts[1], 64'd499);
      end
      check("a_all3_count", n_all3, 1);
      check("a_all3_data", all3_data, 64'd3);
      check("a_dl_events", obs_dl_ts.size(), 1);

      // Periodic stream only
      do_reset();
      clear_logs();
      repeat (1505) step(1'b1, 1'b0, 64'd0, 1'b1);
      check("b_dl_events", obs_dl_ts.size(), 3);
      if (obs_dl_ts.size() >= 3) begin
         check("b_dl_ts0", obs_dl_ts[0], 64'd499);
         check("b_dl_ts1", obs_dl_ts[1], 64'd999);
         check("b_dl_ts2", obs_dl_ts[2], 64'd1499);
      end
      check("b_in_events", obs_in_data.size(), 0);

      // Back-pressure in ISSUE, with an enable-low freeze and ignored input
      clear_logs();
      step(1'b1, 1'b1, 64'd42, 1'b0);
      repeat (3) step(1'b1, 1'b0, 64'd0, 1'b0);
      step(1'b0, 1'b1, 64'd77, 1'b1);
      step(1'b0, 1'b1, 64'd78, 1'b0);
      repeat (3) step(1'b1, 1'b0, 64'd0, 1'b0);
      repeat (6) step(1'b1, 1'b0, 64'd0, 1'b1);
      check("c_in_events", obs_in_data.size(), 1);
      if (obs_in_data.size() >= 1) check("c_data", obs_in_data[0], 64'd42);

      // Back-to-back inputs against a stalled datapath
      clear_logs();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 64'(6 + i), 1'b0);
      repeat (3) step(1'b1, 1'b0, 64'd0, 1'b0);
      check("d_overflow", overflow, 1);
      repeat (40) step(1'b1, 1'b0, 64'd0, 1'b1);
      check("d_some_events", obs_in_data.size() >= 4, 1);
      for (int i = 0; i < obs_in_data.size(); i++) begin
         check("d_order", obs_in_data[i], 64'(6 + i));
      end

      // Reset while evaluating with two entries queued
      step(1'b1, 1'b1, 64'd21, 1'b1);
      step(1'b1, 1'b1, 64'd22, 1'b1);
      step(1'b1, 1'b1, 64'd23, 1'b1);
      check("e_queued_before_rst", mq.size() == 2 && cool == EVAL_CYCLES, 1);
      do_reset();
      clear_logs();
      repeat (20) step(1'b1, 1'b0, 64'd0, 1'b1);
      check("e_no_stale_events", obs_in_data.size() + obs_dl_ts.size(), 0);

      // Random traffic
      for (int i = 0; i < 700; i++) begin
         rv = {$urandom, $urandom};
         step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, rv,
              $urandom_range(0, 9) < 6);
      end
      repeat (30) step(1'b1, 1'b0, 64'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
